// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, framed as start bit,
// DATA_BITS data bits (LSB first), optional parity and one or two stop bits.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, ALIGN, START, DATA, PARITY, STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register updates
  // from the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      shreg      <= '0;
      par        <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          // A tick coinciding with the accept is deliberately not consumed.
          if (valid) begin
            shreg    <= data;
            par      <= (PARITY_ODD != 0) ? ~^data : ^data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx      <= shreg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              // Shifting keeps the next data bit at shreg[1].
              tx      <= shreg[1];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations side by side, a queue of
// expected frames built from the framing rules, and a per-lane line monitor.
module tb_uart_tx_frame;

  localparam int PER = 16;
  localparam int TPH = 5;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] data_v  [3];
  logic       valid_v [3];
  logic       ready_v [3];
  logic       tx_v    [3];
  logic       busy_v  [3];
  logic       fd_v    [3];

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data(data_v[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data(data_v[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
  uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data(data_v[2][6:0]), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

  typedef struct {
    int          lane;
    logic [15:0] bits;
    int          len;
    int          start;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests, n_fail, cyc, frames_sent, frames_done, last_start;

  function automatic int db(int l);  return (l == 2) ? 7 : 8; endfunction
  function automatic bit pe(int l);  return (l != 2);         endfunction
  function automatic bit odd(int l); return (l == 1);         endfunction
  function automatic int sb(int l);  return (l == 2) ? 2 : 1; endfunction

  // Expected line bits plus the cycle the start bit should first be seen.
  function automatic rec_t model(int lane, logic [7:0] d, int acc);
    rec_t r;
    int   ones, pos, t;
    r.lane = lane;
    r.bits = '1;
    r.bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < db(lane); i++) begin
      r.bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    pos = 1 + db(lane);
    if (pe(lane)) begin
      r.bits[pos] = ((ones % 2) == 1) != odd(lane);
      pos++;
    end
    r.len = pos + sb(lane);
    t = acc + 1;
    while ((t % PER) != TPH) t++;
    r.start = t + 1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 baud_tick = ((cyc % PER) == TPH);
    end
  end

  // Line monitor: detects each start edge, samples every bit mid-period and
  // checks frame_done timing against the frame it just decoded.
  bit          act      [3];
  int          st       [3];
  int          done_exp [3];
  rec_t        cur      [3];
  logic [15:0] got      [3];
  int          found, k, idx;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i]      = 1'b0;
        done_exp[i] = -1;
      end else begin
        if (fd_v[i]) begin
          check($sformatf("done_cycle_l%0d", i), cyc, done_exp[i]);
          check($sformatf("done_ready_l%0d", i), ready_v[i], 1);
          done_exp[i] = -1;
          frames_done++;
        end
        if (!act[i] && tx_v[i] == 1'b0) begin
          found = 0;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].lane == i) begin
              cur[i] = exp_q[j];
              exp_q.delete(j);
              found = 1;
              break;
            end
          end
          check($sformatf("start_expected_l%0d", i), found, 1);
          if (found == 1) begin
            act[i] = 1'b1;
            st[i]  = cyc;
            got[i] = '1;
            check($sformatf("start_cycle_l%0d", i), cyc, cur[i].start);
          end
        end
        if (act[i]) begin
          k = cyc - st[i] - PER / 2;
          if (k >= 0 && (k % PER) == 0) begin
            idx = k / PER;
            got[i][idx] = tx_v[i];
            if (idx == cur[i].len - 1) begin
              check($sformatf("frame_bits_l%0d", i), got[i], cur[i].bits);
              act[i]      = 1'b0;
              done_exp[i] = st[i] + PER * cur[i].len;
            end
          end
        end
      end
    end
  end

  task automatic send(input int lane, input logic [7:0] d, input bit hold,
                      input bit on_tick, output bit fd_at);
    int   n;
    rec_t r;
    if (on_tick) begin
      do begin
        @(posedge clk);
        #1;
      end while ((cyc % PER) != TPH);
    end
    data_v[lane]  = d;
    valid_v[lane] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready_v[lane]) break;
      n++;
      if (n > 2000) begin
        check("accept_timeout", ready_v[lane], 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    fd_at = fd_v[lane];
    r = model(lane, d, cyc);
    exp_q.push_back(r);
    frames_sent++;
    last_start = r.start;
    @(posedge clk);
    #1;
    data_v[lane] = 8'($urandom);
    if (!hold) valid_v[lane] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0);
      for (int i = 0; i < 3; i++)
        if (busy_v[i] || act[i] || done_exp[i] != -1) idle = 1'b0;
      @(posedge clk);
      #1;
      if (idle) return;
    end
    check("idle_timeout_queue", exp_q.size(), 0);
    check("idle_timeout_busy0", busy_v[0], 0);
  endtask

  initial begin
    bit fd_at;
    int lane, cnt, stop_at;
    n_tests = 0; n_fail = 0; frames_sent = 0; frames_done = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_v[i] = 1'b0;
      data_v[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx_l%0d", i), tx_v[i], 1);
      check($sformatf("rst_ready_l%0d", i), ready_v[i], 1);
      check($sformatf("rst_busy_l%0d", i), busy_v[i], 0);
      check($sformatf("rst_done_l%0d", i), fd_v[i], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(0, 8'hA5, 0, 0, fd_at);
    send(1, 8'hA5, 0, 0, fd_at);
    send(1, 8'h00, 0, 0, fd_at);
    send(2, 8'h41, 0, 0, fd_at);
    wait_idle();

    // valid lands on a tick cycle: the start bit must wait a full period.
    send(0, 8'h3C, 0, 1, fd_at);
    wait_idle();

    send(0, 8'h55, 1, 0, fd_at);
    send(0, 8'h0F, 0, 0, fd_at);
    check("b2b_accept_on_done", fd_at, 1);
    wait_idle();

    send(0, 8'hFF, 0, 0, fd_at);
    stop_at = last_start + 4 * PER + 6;
    while (cyc < stop_at) @(posedge clk);
    #3 rst_n = 1'b0;
    frames_sent--;
    #1;
    check("midrst_tx_high", tx_v[0], 1);
    check("midrst_ready", ready_v[0], 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", ready_v[0], 1);
    check("postrst_busy", busy_v[0], 0);
    repeat (40) @(posedge clk);
    #1;
    send(0, 8'hC3, 0, 0, fd_at);
    wait_idle();

    for (int n = 0; n < 8; n++) begin
      lane = $urandom_range(0, 2);
      cnt  = $urandom_range(1, 3);
      for (int j = 0; j < cnt; j++)
        send(lane, 8'($urandom), (j < cnt - 1), 0, fd_at);
      repeat ($urandom_range(0, 30)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    check("frames_completed", frames_done, frames_sent);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
